v_lane_data_fifo: RTL and testbench

V_LANE_DATA_FIFO -- requirements
Module: v_lane_data_fifo

---
 rtl/configurations_pkg.sv | 15 +
 rtl/v_lane_fifo_ram.sv | 38 +++
 rtl/v_lane_data_fifo.sv | 135 +++++++++++++
 tb/tb_v_lane_data_fifo.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/configurations_pkg.sv
// Shared configuration defaults for the vector lane and its load/store FIFOs.
package configurations_pkg;

  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned VECTOR_LENGTH       = 8;
  localparam int unsigned FIFO_DEPTH          = 512;
  localparam int unsigned ALMOST_FULL_OFFSET  = 16;
  localparam int unsigned ALMOST_EMPTY_OFFSET = 16;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/v_lane_fifo_ram.sv
// Simple dual-port RAM for the lane FIFOs: one write port, one registered read port.
// Read-first on an address collision, so the read port returns the old word.
module v_lane_fifo_ram import configurations_pkg::*; #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = ptr_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register carries a synchronous reset; the array itself is never cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/v_lane_data_fifo.sv
// Synchronous lane data FIFO with occupancy, almost flags and overflow/underflow pulses.
// Define V_LANE_FIFO_FWFT_EN for first-word-fall-through output; default is read latency 1.
module v_lane_data_fifo #(
  parameter int unsigned DATA_WIDTH          = configurations_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH               = configurations_pkg::FIFO_DEPTH,
  parameter int unsigned ALMOST_FULL_OFFSET  = configurations_pkg::ALMOST_FULL_OFFSET,
  parameter int unsigned ALMOST_EMPTY_OFFSET = configurations_pkg::ALMOST_EMPTY_OFFSET
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         re_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almostfull_o,
  output logic                         almostempty_o,
  output logic [$clog2(DEPTH)-1:0]     wrcount_o,
  output logic [$clog2(DEPTH)-1:0]     rdcount_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         wrerr_o,
  output logic                         rderr_o
);

  localparam int unsigned AW = configurations_pkg::ptr_width(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt   = CW'(DEPTH - ALMOST_FULL_OFFSET);
  localparam logic [CW-1:0] AeCnt   = CW'(ALMOST_EMPTY_OFFSET);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrerr_q, wrerr_d;
  logic          rderr_q, rderr_d;
  logic          wr_acc, rd_acc;
  logic          full, empty;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);

  // A write into a full FIFO is accepted only when a read frees the slot in the same cycle.
  always_comb begin
    rd_acc   = re_i & ~empty;
    wr_acc   = we_i & (~full | rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wrerr_d = we_i & ~wr_acc;
    rderr_d = re_i & ~rd_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wrerr_q  <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wrerr_q  <= wrerr_d;
      rderr_q  <= rderr_d;
    end
  end

  logic                  ram_we, ram_re;
  logic [AW-1:0]         ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign ram_we = wr_acc & ~reset;

`ifdef V_LANE_FIFO_FWFT_EN
  // RAM always prefetches the next head; a write landing on that slot is bypassed
  // because the read port would still return the pre-write word.
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_data_q;

  assign ram_re    = 1'b1;
  assign ram_raddr = rd_ptr_d;
  assign byp_sel_d = wr_acc & (wr_ptr_q == rd_ptr_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_sel_q <= byp_sel_d;
      if (byp_sel_d) byp_data_q <= data_i;
    end
  end

  assign data_o = byp_sel_q ? byp_data_q : ram_rdata;
`else
  assign ram_re    = rd_acc & ~reset;
  assign ram_raddr = rd_ptr_q;
  assign data_o    = ram_rdata;
`endif

  v_lane_fifo_ram #(
    .Width (DATA_WIDTH),
    .Depth (DEPTH),
    .AddrW (AW)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_i),
    .rd_en_i   (ram_re),
    .rd_addr_i (ram_raddr),
    .rd_data_o (ram_rdata)
  );

  assign full_o        = full;
  assign empty_o       = empty;
  assign almostfull_o  = (count_q >= AfCnt);
  assign almostempty_o = (count_q <= AeCnt);
  assign wrcount_o     = wr_ptr_q;
  assign rdcount_o     = rd_ptr_q;
  assign count_o       = count_q;
  assign wrerr_o       = wrerr_q;
  assign rderr_o       = rderr_q;

endmodule

// File: tb/tb_v_lane_data_fifo.sv
// Scoreboard bench for v_lane_data_fifo at DEPTH=8, offsets=2; honours V_LANE_FIFO_FWFT_EN.
module tb_v_lane_data_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we_i = 1'b0;
  logic          re_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          full_o, empty_o, almostfull_o, almostempty_o, wrerr_o, rderr_o;
  logic [2:0]    wrcount_o, rdcount_o;
  logic [3:0]    count_o;

  v_lane_data_fifo #(
    .DATA_WIDTH          (DW),
    .DEPTH               (D),
    .ALMOST_FULL_OFFSET  (2),
    .ALMOST_EMPTY_OFFSET (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .we_i          (we_i),
    .data_i        (data_i),
    .re_i          (re_i),
    .data_o        (data_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almostfull_o  (almostfull_o),
    .almostempty_o (almostempty_o),
    .wrcount_o     (wrcount_o),
    .rdcount_o     (rdcount_o),
    .count_o       (count_o),
    .wrerr_o       (wrerr_o),
    .rderr_o       (rderr_o)
  );

  always #5 clk = ~clk;

  // Scoreboard model state
  logic [DW-1:0] m_q[$];
  logic [2:0]    m_wr, m_rd;
  logic          m_wrerr, m_rderr;
  logic [DW-1:0] m_last;
  logic          popped;
  logic [DW-1:0] pop_val, pre_data, rd_seen;
  int            n_checks = 0;
  int            n_fail   = 0;

  wire [15:0] dut_status = {count_o, wrcount_o, rdcount_o, full_o, empty_o,
                            almostfull_o, almostempty_o, wrerr_o, rderr_o};

  function automatic logic [15:0] model_status();
    int n;
    n = m_q.size();
    return {4'(n), m_wr, m_rd, n == 8, n == 0, n >= 6, n <= 2, m_wrerr, m_rderr};
  endfunction

  function automatic logic model_data_known();
`ifdef V_LANE_FIFO_FWFT_EN
    return m_q.size() > 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [DW-1:0] model_data();
`ifdef V_LANE_FIFO_FWFT_EN
    return (m_q.size() > 0) ? m_q[0] : '0;
`else
    return m_last;
`endif
  endfunction

  // Drive one cycle and advance the model; comparisons are left to the calling test.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic re);
    logic rd_ok, wr_ok;
    @(negedge clk);
    we_i = we; data_i = d; re_i = re;
    #1;
    pre_data = data_o;
    rd_ok = re && (m_q.size() > 0);
    wr_ok = we && ((m_q.size() < D) || rd_ok);
    popped = rd_ok;
    if (rd_ok) begin
      pop_val = m_q.pop_front();
      m_rd    = m_rd + 3'd1;
      m_last  = pop_val;
    end
    if (wr_ok) begin
      m_q.push_back(d);
      m_wr = m_wr + 3'd1;
    end
    m_wrerr = we && !wr_ok;
    m_rderr = re && !rd_ok;
    @(posedge clk);
    #1;
    we_i = 1'b0; re_i = 1'b0;
`ifdef V_LANE_FIFO_FWFT_EN
    rd_seen = pre_data;
`else
    rd_seen = data_o;
`endif
  endtask

  task automatic do_reset(input int cycles, input logic we, input logic re);
    @(negedge clk);
    reset = 1'b1; we_i = we; re_i = re; data_i = 32'hBAD0_BAD0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0; we_i = 1'b0; re_i = 1'b0;
    m_q.delete();
    m_wr = '0; m_rd = '0; m_wrerr = 1'b0; m_rderr = 1'b0; m_last = '0;
  endtask

  task automatic test_reset();
    do_reset(2, 1'b0, 1'b0);
    n_checks++;
    if (dut_status !== model_status()) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected %h", dut_status, model_status());
    end
    n_checks++;
    if (data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00000000", data_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b0);
      n_checks++;
      if (dut_status !== model_status()) begin
        n_fail++;
        $display("FAIL fill_status[%0d]: got %h expected %h", i, dut_status, model_status());
      end
      if (i == 3) begin
        n_checks++;
        if (almostempty_o !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_almostempty: got %b expected 0", almostempty_o);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (almostfull_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_almostfull: got %b expected 1", almostfull_o);
        end
      end
    end
    n_checks++;
    if ({full_o, wrcount_o} !== 4'b1_000) begin
      n_fail++;
      $display("FAIL fill_full_wrcount: got %b/%0d expected 1/0", full_o, wrcount_o);
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (m_q.size() > 0 && guard < 2 * D) begin
      guard++;
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (rd_seen !== pop_val || dut_status !== model_status()) begin
        n_fail++;
        $display("FAIL %s_read: got %h/%h expected %h/%h", tag, rd_seen, dut_status,
                 pop_val, model_status());
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 32'hDEAD, 1'b0);
    n_checks++;
    if (wrerr_o !== 1'b1 || count_o !== 4'd8 || dut_status !== model_status()) begin
      n_fail++;
      $display("FAIL overflow_pulse: got %h expected %h", dut_status, model_status());
    end
    step(1'b0, '0, 1'b0);
    n_checks++;
    if (wrerr_o !== 1'b0 || count_o !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow_clear: got wrerr=%b count=%0d expected 0/8", wrerr_o, count_o);
    end
    drain("overflow");
  endtask

  task automatic test_underflow();
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (rderr_o !== 1'b1 || dut_status !== model_status()) begin
      n_fail++;
      $display("FAIL underflow_pulse: got %h expected %h", dut_status, model_status());
    end
`ifndef V_LANE_FIFO_FWFT_EN
    n_checks++;
    if (data_o !== m_last) begin
      n_fail++;
      $display("FAIL underflow_data_hold: got %h expected %h", data_o, m_last);
    end
`endif
    step(1'b0, '0, 1'b0);
    n_checks++;
    if (rderr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clear: got %b expected 0", rderr_o);
    end
    step(1'b1, 32'h55, 1'b1);
    n_checks++;
    if (rderr_o !== 1'b1 || count_o !== 4'd1 || dut_status !== model_status()) begin
      n_fail++;
      $display("FAIL underflow_wr_rd: got %h expected %h", dut_status, model_status());
    end
    n_checks++;
    if (model_data_known() && data_o !== model_data()) begin
      n_fail++;
      $display("FAIL underflow_wr_rd_data: got %h expected %h", data_o, model_data());
    end
    drain("underflow");
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 32'h9, 1'b1);
    n_checks++;
    if (count_o !== 4'd8 || rd_seen !== 32'h1 || dut_status !== model_status()) begin
      n_fail++;
      $display("FAIL full_simul: got %h/%h expected 00000001/%h", rd_seen, dut_status,
               model_status());
    end
    drain("full_simul");
    n_checks++;
    if (pop_val !== 32'h9 || rd_seen !== 32'h9) begin
      n_fail++;
      $display("FAIL full_simul_last: got %h expected 00000009", rd_seen);
    end
  endtask

  task automatic test_wrap();
    int wraps;
    logic [2:0] prev_rd;
    wraps = 0;
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h101, 1'b0);
    for (int i = 2; i < 20; i++) begin
      prev_rd = rdcount_o;
      step(1'b1, 32'h100 + DW'(i), 1'b1);
      if (prev_rd == 3'd7 && rdcount_o == 3'd0) wraps++;
      n_checks++;
      if (rd_seen !== pop_val || dut_status !== model_status() || wrerr_o || rderr_o) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h/%h expected %h/%h", i, rd_seen, dut_status,
                 pop_val, model_status());
      end
    end
    drain("wrap");
    n_checks++;
    if (wraps < 1) begin
      n_fail++;
      $display("FAIL wrap_pointer: got %0d rd wraps expected >=1", wraps);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + DW'(i), 1'b0);
    do_reset(1, 1'b1, 1'b1);
    n_checks++;
    if (dut_status !== model_status() || data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%h expected %h/00000000", dut_status, data_o,
               model_status());
    end
    step(1'b1, 32'h77, 1'b0);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (rd_seen !== 32'h77 || dut_status !== model_status()) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %h/%h expected 00000077/%h", rd_seen, dut_status,
               model_status());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
